// File: rtl/pwm_dt_gen_if.sv
// pwm_dt_gen_if: enable/duty toward the PWM core, complementary gate drives and period strobe back.
interface pwm_dt_gen_if #(
    parameter int BITS   = 8,
    parameter int PHASES = 1
);
    logic              ena;
    logic [BITS-1:0]   duty;
    logic [PHASES-1:0] pwm_out;
    logic [PHASES-1:0] pwm_n_out;
    logic              period_start;
    modport master (output ena, duty, input pwm_out, pwm_n_out, period_start);
    modport slave  (input ena, duty, output pwm_out, pwm_n_out, period_start);
endinterface

// File: rtl/pwm_dt_gen.sv
// pwm_dt_gen: multi-phase complementary PWM with shadowed duty and dead-time insertion.
module pwm_dt_gen #(
    parameter int BITS   = 8,
    parameter int PHASES = 1,
    parameter int PRESC  = 1,
    parameter int DEAD   = 2
) (
    input logic         clk,
    input logic         reset,
    pwm_dt_gen_if.slave bus
);
    localparam int PW  = PRESC > 1 ? $clog2(PRESC) : 1;
    localparam int DW  = DEAD > 0 ? $clog2(DEAD + 1) : 1;
    localparam int OFS = (2 ** BITS) / PHASES;
    typedef enum logic [1:0] {DEAD_WAIT, HI, LO} state_e;
    logic [PW-1:0]     pre_q;
    logic [BITS-1:0]   cnt_q, duty_sh_q;
    logic              ena_q, rvld_q, run_q, ps_q;
    logic [PHASES-1:0] raw_d, raw_q, pwm_v, pwm_n_v;
    logic              tick, count_en, load;
    // The counter stays parked during the enable cycle so the first period is full length.
    assign tick     = pre_q == PW'(PRESC - 1);
    assign count_en = bus.ena & ena_q;
    assign load     = bus.ena & (~ena_q | (tick & (&cnt_q)));
    always_comb begin
        raw_d = '0;
        for (int k = 0; k < PHASES; k++) raw_d[k] = (cnt_q + BITS'(k * OFS)) < duty_sh_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q     <= '0;
            cnt_q     <= '0;
            duty_sh_q <= '0;
            ena_q     <= 1'b0;
            rvld_q    <= 1'b0;
            run_q     <= 1'b0;
            ps_q      <= 1'b0;
            raw_q     <= '0;
        end else begin
            ena_q  <= bus.ena;
            rvld_q <= count_en;
            run_q  <= bus.ena & rvld_q;
            ps_q   <= load;
            if (load) duty_sh_q <= bus.duty;
            pre_q  <= count_en ? (tick ? '0 : pre_q + PW'(1)) : '0;
            cnt_q  <= count_en ? cnt_q + BITS'(tick) : '0;
            raw_q  <= count_en ? raw_d : '0;
        end
    end
    // First valid compare after enable is treated as an edge so both sides wait the dead-time.
    for (genvar g = 0; g < PHASES; g++) begin : g_ph
        state_e        st_q;
        logic [DW-1:0] dcnt_q;
        logic          lvl_q, p_q, n_q;
        always_ff @(posedge clk) begin
            if (reset || !bus.ena || !rvld_q) begin
                st_q   <= DEAD_WAIT;
                dcnt_q <= DW'(DEAD);
                lvl_q  <= 1'b0;
                p_q    <= 1'b0;
                n_q    <= 1'b0;
            end else if (!run_q || raw_q[g] != lvl_q) begin
                lvl_q  <= raw_q[g];
                dcnt_q <= DW'(DEAD);
                st_q   <= DEAD == 0 ? (raw_q[g] ? HI : LO) : DEAD_WAIT;
                p_q    <= DEAD == 0 && raw_q[g];
                n_q    <= DEAD == 0 && !raw_q[g];
            end else if (st_q == DEAD_WAIT) begin
                if (dcnt_q <= DW'(1)) begin
                    st_q <= raw_q[g] ? HI : LO;
                    p_q  <= raw_q[g];
                    n_q  <= ~raw_q[g];
                end
                if (dcnt_q != '0) dcnt_q <= dcnt_q - DW'(1);
            end
        end
        assign pwm_v[g]   = p_q;
        assign pwm_n_v[g] = n_q;
    end
    assign bus.pwm_out      = pwm_v;
    assign bus.pwm_n_out    = pwm_n_v;
    assign bus.period_start = ps_q;
endmodule

// File: tb/tb_pwm_dt_gen.sv
// tb_pwm_dt_gen: directed checks of duty, dead-time, shadowing, enable/reset and phase offset.
module tb_pwm_dt_gen;
    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       ena   = 1'b0;
    logic [7:0] duty  = '0;
    int tests = 0, fails = 0, cyc = 0, overlap = 0;
    int h0, n0, h1, n1, ps0, x2, t0, t1, ta, tb2, ts;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_dt_gen_if #(.BITS(8), .PHASES(1)) if0 ();
    pwm_dt_gen_if #(.BITS(8), .PHASES(1)) if1 ();
    pwm_dt_gen_if #(.BITS(8), .PHASES(2)) if2 ();
    assign if0.ena = ena;
    assign if1.ena = ena;
    assign if2.ena = ena;
    assign if0.duty = duty;
    assign if1.duty = duty;
    assign if2.duty = duty;

    pwm_dt_gen #(.BITS(8), .PHASES(1), .PRESC(1), .DEAD(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
    pwm_dt_gen #(.BITS(8), .PHASES(1), .PRESC(1), .DEAD(2)) u1 (.clk(clk), .reset(reset), .bus(if1));
    pwm_dt_gen #(.BITS(8), .PHASES(2), .PRESC(4), .DEAD(2)) u2 (.clk(clk), .reset(reset), .bus(if2));

    always @(negedge clk)
        if ((if0.pwm_out & if0.pwm_n_out) != 0 || (if1.pwm_out & if1.pwm_n_out) != 0 ||
            (if2.pwm_out & if2.pwm_n_out) != 0) overlap++;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        h0 = 0; n0 = 0; h1 = 0; n1 = 0; ps0 = 0; x2 = 0;
    endtask

    task automatic meas(input int n);
        repeat (n) begin
            h0  += int'(if0.pwm_out[0]);
            n0  += int'(if0.pwm_n_out[0]);
            h1  += int'(if1.pwm_out[0]);
            n1  += int'(if1.pwm_n_out[0]);
            ps0 += int'(if0.period_start);
            x2  += int'(|{if2.pwm_out, if2.pwm_n_out, if2.period_start});
            @(negedge clk);
        end
    endtask

    task automatic wait_ps(input int which, input int lim);
        logic hit;
        int   i;
        i = 0;
        @(negedge clk);
        hit = which == 2 ? if2.period_start : if0.period_start;
        while (!hit && i < lim) begin
            @(negedge clk);
            i++;
            hit = which == 2 ? if2.period_start : if0.period_start;
        end
        chk("ps_found", int'(hit), 1);
    endtask

    task automatic rise(input logic hi, output int r0, output int r1);
        r0 = -1;
        r1 = -1;
        for (int i = 0; i < 16; i++) begin
            if (r0 < 0 && (hi ? if0.pwm_out[0] : if0.pwm_n_out[0])) r0 = i;
            if (r1 < 0 && (hi ? if1.pwm_out[0] : if1.pwm_n_out[0])) r1 = i;
            @(negedge clk);
        end
    endtask

    task automatic wait_rise(input int b, input int lim, output int t);
        logic prev;
        prev = if2.pwm_out[b];
        t = -1;
        for (int i = 0; i < lim && t < 0; i++) begin
            @(negedge clk);
            if (!prev && if2.pwm_out[b]) t = cyc;
            prev = if2.pwm_out[b];
        end
        chk("rise_found", int'(t >= 0), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state", int'({if0.pwm_out, if0.pwm_n_out, if0.period_start, if1.pwm_out, if1.pwm_n_out}), 0);
        reset = 1'b0;
        clr();
        meas(1000);
        chk("dis_outs", h0 + n0 + h1 + n1 + x2, 0);
        chk("dis_ps", ps0, 0);

        ena = 1'b1;
        @(negedge clk);
        chk("en_ps", int'(if0.period_start), 1);
        rise(1'b0, t0, t1);
        chk("en_lat_d0", t0, 2);
        chk("en_lat_d2", t1, 4);

        duty = 8'd64;
        wait_ps(0, 300);
        repeat (2) @(negedge clk);
        clr();
        meas(256);
        chk("d64_hi_d0", h0, 64);
        chk("d64_lo_d0", n0, 192);
        chk("d64_hi_d2", h1, 62);
        chk("d64_lo_d2", n1, 190);
        chk("d64_ps", ps0, 1);

        clr();
        meas(50);
        duty = 8'd200;
        meas(206);
        chk("shadow_cur", h0, 64);
        clr();
        meas(256);
        chk("shadow_next_hi", h0, 200);
        chk("shadow_next_lo", n0, 56);

        duty = 8'd128;
        wait_ps(0, 300);
        repeat (2) @(negedge clk);
        clr();
        meas(256);
        chk("d128_hi_d0", h0, 128);
        chk("d128_lo_d0", n0, 128);
        chk("d128_hi_d2", h1, 126);
        chk("d128_lo_d2", n1, 126);

        duty = 8'd0;
        wait_ps(0, 300);
        repeat (2) @(negedge clk);
        clr();
        meas(256);
        chk("d0_hi", h0 + h1, 0);
        chk("d0_lo_d0", n0, 256);

        duty = 8'd255;
        wait_ps(0, 300);
        repeat (2) @(negedge clk);
        clr();
        meas(256);
        chk("d255_hi_d0", h0, 255);
        chk("d255_lo_d0", n0, 1);
        chk("d255_hi_d2", h1, 253);
        chk("d255_lo_d2", n1, 0);

        duty = 8'd2;
        wait_ps(0, 300);
        repeat (2) @(negedge clk);
        clr();
        meas(256);
        chk("d2_hi_d0", h0, 2);
        chk("d2_hi_d2", h1, 0);

        wait_ps(0, 300);
        ts = cyc;
        wait_ps(0, 300);
        chk("ps_gap_p1", cyc - ts, 256);

        duty = 8'd128;
        wait_ps(0, 300);
        repeat (20) @(negedge clk);
        chk("pre_dis_hi", int'({if0.pwm_out[0], if1.pwm_out[0]}), 3);
        ena = 1'b0;
        @(negedge clk);
        chk("dis_drop", int'({if0.pwm_out, if0.pwm_n_out, if1.pwm_out, if1.pwm_n_out}), 0);
        repeat (3) @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        chk("reen_ps", int'(if0.period_start), 1);
        rise(1'b1, t0, t1);
        chk("reen_lat_d0", t0, 2);
        chk("reen_lat_d2", t1, 4);

        chk("pre_rst_hi", int'(if1.pwm_out[0]), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_drop", int'({if0.pwm_out, if0.pwm_n_out, if1.pwm_out, if1.pwm_n_out, if0.period_start}), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ps", int'(if0.period_start), 1);
        rise(1'b1, t0, t1);
        chk("rst_lat_d0", t0, 2);
        chk("rst_lat_d2", t1, 4);

        duty = 8'd64;
        wait_ps(2, 1100);
        wait_rise(0, 1200, ta);
        wait_rise(1, 1200, tb2);
        chk("phase_lag", tb2 - ta, 512);
        wait_ps(2, 1100);
        ts = cyc;
        wait_ps(2, 1100);
        chk("ps_gap_p4", cyc - ts, 1024);

        chk("no_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
